// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle stream consumer: field layout of an
// obstacle word, table geometry, payload structs and the FSM state encoding.
package obstacle_pkg;

  localparam int unsigned NUM_ROWS    = 16;
  localparam int unsigned NUM_LANES   = 3;
  localparam int unsigned NUM_ENTRIES = NUM_ROWS * NUM_LANES;

  localparam int unsigned WORD_WIDTH  = 16;
  localparam int unsigned TYPE_MSB    = 15;
  localparam int unsigned LANE_LSB    = 11;
  localparam int unsigned LANE_WIDTH  = 2;
  localparam int unsigned DEPTH_WIDTH = 11;
  localparam int unsigned TYPE_WIDTH  = TYPE_MSB - LANE_LSB - LANE_WIDTH + 1;

  localparam int unsigned ROW_WIDTH   = $clog2(NUM_ROWS);
  localparam int unsigned ADDR_WIDTH  = $clog2(NUM_ENTRIES);
  localparam int unsigned COUNT_WIDTH = 8;

  typedef enum logic [TYPE_WIDTH-1:0] {
    NONE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    MID   = 3'd3,
    TRAIN = 3'd4,
    RAMP  = 3'd5,
    CAR   = 3'd6
  } obs_type_e;

  // Obstacle word as it arrives on the stream.
  typedef struct packed {
    logic [TYPE_WIDTH-1:0]  otype;
    logic [LANE_WIDTH-1:0]  lane;
    logic [DEPTH_WIDTH-1:0] depth;
  } obstacle_t;

  // Payload held per table entry.
  typedef struct packed {
    logic [TYPE_WIDTH-1:0]  otype;
    logic [DEPTH_WIDTH-1:0] depth;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SWAP    = 2'd2
  } state_e;

  // Flat table address of (row, lane); only meaningful for legal lanes.
  function automatic logic [ADDR_WIDTH-1:0] entry_addr(
    input logic [ROW_WIDTH-1:0]  row,
    input logic [LANE_WIDTH-1:0] lane
  );
    return ADDR_WIDTH'(row) * ADDR_WIDTH'(NUM_LANES) + ADDR_WIDTH'(lane);
  endfunction

endpackage

// File: rtl/obstacle_receiver_if.sv
// Stream input, read port and status of the obstacle receiver.
//   master: producer/reader side (drives in_*, rd_en/rd_row/rd_lane)
//   slave : receiver side (drives rd_*, frame_ready, frame_count, proto_err)
interface obstacle_receiver_if;
  import obstacle_pkg::*;

  logic                   in_valid;
  logic                   in_first_row;
  logic [WORD_WIDTH-1:0]  in_obstacle;
  logic                   in_done;
  logic                   rd_en;
  logic [ROW_WIDTH-1:0]   rd_row;
  logic [LANE_WIDTH-1:0]  rd_lane;
  logic                   rd_valid;
  logic [TYPE_WIDTH-1:0]  rd_type;
  logic [DEPTH_WIDTH-1:0] rd_depth;
  logic                   frame_ready;
  logic [COUNT_WIDTH-1:0] frame_count;
  logic                   proto_err;

  modport master (
    output in_valid, in_first_row, in_obstacle, in_done, rd_en, rd_row, rd_lane,
    input  rd_valid, rd_type, rd_depth, frame_ready, frame_count, proto_err
  );

  modport slave (
    input  in_valid, in_first_row, in_obstacle, in_done, rd_en, rd_row, rd_lane,
    output rd_valid, rd_type, rd_depth, frame_ready, frame_count, proto_err
  );

endinterface

// File: rtl/obstacle_bank.sv
// One 48-entry obstacle table with occupancy bits.
//   clk, rst_n          : clock, async active-low reset (clears occupancy/read reg)
//   clr                 : clear all occupancy bits (a same-cycle write still lands)
//   we, wr_row, wr_lane : write wr_entry at (wr_row, wr_lane); lane must be legal
//   rd_en, rd_row, rd_lane, rd_entry : registered read, zeros if unoccupied/illegal
module obstacle_bank
  import obstacle_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ROW_WIDTH-1:0]  wr_row,
  input  logic [LANE_WIDTH-1:0] wr_lane,
  input  entry_t                wr_entry,
  input  logic                  rd_en,
  input  logic [ROW_WIDTH-1:0]  rd_row,
  input  logic [LANE_WIDTH-1:0] rd_lane,
  output entry_t                rd_entry
);

  entry_t                  table_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  occ_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_c;
  logic [ADDR_WIDTH-1:0]   rd_addr_c;
  logic                    rd_hit_c;

  assign wr_addr_c = entry_addr(wr_row, wr_lane);
  assign rd_addr_c = entry_addr(rd_row, rd_lane);
  // Lane 3 would alias the next row, so it is rejected before the lookup.
  assign rd_hit_c  = (rd_lane < LANE_WIDTH'(NUM_LANES)) && occ_q[rd_addr_c];

  // Payload storage; stale contents are masked by occupancy.
  always_ff @(posedge clk) begin
    if (we) begin
      table_q[wr_addr_c] <= wr_entry;
    end
  end

  // Occupancy and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      rd_entry <= '0;
    end else begin
      if (clr) begin
        occ_q <= '0;
      end
      if (we) begin
        occ_q[wr_addr_c] <= 1'b1;
      end
      if (rd_en) begin
        rd_entry <= rd_hit_c ? table_q[rd_addr_c] : '0;
      end
    end
  end

endmodule

// File: rtl/obstacle_receiver.sv
// Double-buffered receiver for the obstacle stream. Collects a frame into the
// write bank, swaps banks on in_done so reads only ever see complete frames.
//   clk, rst_n : clock, async active-low reset
//   bus        : stream input, registered read port, frame_ready/frame_count/proto_err
module obstacle_receiver
  import obstacle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  obstacle_receiver_if.slave bus
);

  state_e                 state_q, state_d;
  logic                   rd_bank_q;
  logic [ROW_WIDTH-1:0]   wr_row_q, wr_row_d;
  logic                   full_q, full_d;
  logic                   proto_err_q;
  logic                   frame_ready_q;
  logic [COUNT_WIDTH-1:0] frame_count_q;
  logic                   rd_valid_q;
  logic                   rd_sel_q;

  obstacle_t              word_c;
  entry_t                 wr_entry_c;
  logic                   lane_ok_c;
  logic                   last_lane_c;
  logic                   start_c;
  logic                   we_c;
  logic                   clr_c;
  logic                   err_c;
  logic                   swap_c;
  logic                   wr_bank_c;
  logic [ROW_WIDTH-1:0]   wr_row_c;
  entry_t                 rd0_entry, rd1_entry;

  assign word_c           = bus.in_obstacle;
  assign wr_entry_c.otype = word_c.otype;
  assign wr_entry_c.depth = word_c.depth;
  assign lane_ok_c        = word_c.lane < LANE_WIDTH'(NUM_LANES);
  assign last_lane_c      = word_c.lane == LANE_WIDTH'(NUM_LANES - 1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and write control.
  always_comb begin
    state_d   = state_q;
    wr_row_d  = wr_row_q;
    full_d    = full_q;
    wr_row_c  = wr_row_q;
    start_c   = 1'b0;
    we_c      = 1'b0;
    clr_c     = 1'b0;
    err_c     = 1'b0;
    swap_c    = 1'b0;
    wr_bank_c = ~rd_bank_q;

    case (state_q)
      ST_IDLE, ST_SWAP: begin
        if (state_q == ST_SWAP) begin
          // Bank toggles at this edge; a new frame goes into the outgoing read bank.
          swap_c    = 1'b1;
          wr_bank_c = rd_bank_q;
          state_d   = ST_IDLE;
        end
        if (bus.in_valid) begin
          if (bus.in_first_row) begin
            start_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (bus.in_valid) begin
          if (bus.in_first_row) begin
            start_c = 1'b1;
            err_c   = 1'b1;
          end else if (!lane_ok_c || full_q) begin
            err_c = 1'b1;
          end else begin
            we_c = 1'b1;
            if (last_lane_c) begin
              if (wr_row_q == ROW_WIDTH'(NUM_ROWS - 1)) begin
                full_d = 1'b1;
              end else begin
                wr_row_d = wr_row_q + ROW_WIDTH'(1);
              end
            end
          end
        end
        if (bus.in_done) begin
          state_d = ST_SWAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start (or restart): discard the write bank and write at row 0.
    if (start_c) begin
      clr_c    = 1'b1;
      full_d   = 1'b0;
      wr_row_c = '0;
      wr_row_d = '0;
      if (state_q != ST_COLLECT) begin
        state_d = ST_COLLECT;
      end
      if (lane_ok_c) begin
        we_c = 1'b1;
        if (last_lane_c) begin
          wr_row_d = ROW_WIDTH'(1);
        end
      end else begin
        err_c = 1'b1;
      end
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q     <= 1'b0;
      wr_row_q      <= '0;
      full_q        <= 1'b0;
      proto_err_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_count_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_sel_q      <= 1'b0;
    end else begin
      wr_row_q      <= wr_row_d;
      full_q        <= full_d;
      frame_ready_q <= swap_c;
      rd_valid_q    <= bus.rd_en;
      if (err_c) begin
        proto_err_q <= 1'b1;
      end
      if (swap_c) begin
        rd_bank_q     <= ~rd_bank_q;
        frame_count_q <= frame_count_q + COUNT_WIDTH'(1);
      end
      // Remember which bank served the read; a read in the swap cycle uses the old one.
      if (bus.rd_en) begin
        rd_sel_q <= rd_bank_q;
      end
    end
  end

  obstacle_bank u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_c & ~wr_bank_c),
    .we       (we_c & ~wr_bank_c),
    .wr_row   (wr_row_c),
    .wr_lane  (word_c.lane),
    .wr_entry (wr_entry_c),
    .rd_en    (bus.rd_en),
    .rd_row   (bus.rd_row),
    .rd_lane  (bus.rd_lane),
    .rd_entry (rd0_entry)
  );

  obstacle_bank u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_c & wr_bank_c),
    .we       (we_c & wr_bank_c),
    .wr_row   (wr_row_c),
    .wr_lane  (word_c.lane),
    .wr_entry (wr_entry_c),
    .rd_en    (bus.rd_en),
    .rd_row   (bus.rd_row),
    .rd_lane  (bus.rd_lane),
    .rd_entry (rd1_entry)
  );

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_type     = rd_sel_q ? rd1_entry.otype : rd0_entry.otype;
  assign bus.rd_depth    = rd_sel_q ? rd1_entry.depth : rd0_entry.depth;
  assign bus.frame_ready = frame_ready_q;
  assign bus.frame_count = frame_count_q;
  assign bus.proto_err   = proto_err_q;

endmodule

// File: doc/obstacle_receiver.md
Name: obstacle_receiver

Overview:
- Consumer end of the obstacle stream produced by the obstacle generator.
- Collects one frame of 16-bit obstacle words (3b type, 2b lane, 11b depth) into a write bank of a double-buffered 16x3 table.
- Swaps banks on the frame-done pulse, so renderer and collision logic always read a complete, stable frame through a registered read port.

Parameters:
- NUM_ROWS, 16, rows per frame (row index width = clog2(NUM_ROWS)).
- NUM_LANES, 3, lanes per row; lane codes 0..NUM_LANES-1 are legal.
- DEPTH_WIDTH, 11, width of the depth field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe: in_obstacle is a word
- in_first_row  in  1  qualifies in_valid: word belongs to row 0 and starts a frame
- in_obstacle  in  16  [15:13] type, [12:11] lane, [10:0] depth
- in_done  in  1  one-cycle pulse: frame complete
- rd_en  in  1  read request
- rd_row  in  4  row to read
- rd_lane  in  2  lane to read
- rd_valid  out  1  read data valid, exactly 1 cycle after rd_en
- rd_type  out  3  stored type (000 if entry not written this frame)
- rd_depth  out  11  stored depth (0 if entry not written)
- frame_ready  out  1  one-cycle pulse when a new frame becomes readable
- frame_count  out  8  completed frames, wraps 255->0
- proto_err  out  1  sticky protocol error; cleared only by reset

Behaviour:
- Reset (async assert, sync release): both banks' occupancy bits cleared, read bank = 0, state IDLE. rd_valid, rd_type, rd_depth, frame_ready, frame_count and proto_err all 0.
- Storage: per bank, 48 entries of {type, depth} plus a 48-bit occupancy vector. Address = row*3 + lane.
- Row tracking: write row counter wr_row (4b). It advances after accepting a word whose lane == 2.
- IDLE:
  - in_valid && in_first_row: clear write-bank occupancy, set wr_row = 0, write the word, go to COLLECT.
  - in_valid without first_row: drop the word, set proto_err.
  - in_done in IDLE: ignored; no swap.
- COLLECT:
  - Each in_valid word is written at [wr_row][lane] and sets its occupancy bit.
  - Lane code 3: word dropped, proto_err set, wr_row unchanged.
  - Word arriving after wr_row has passed row 15 with lane 2 (overflow): dropped, proto_err set.
  - in_valid && in_first_row: restart. Occupancy is cleared, the word is written at row 0, and proto_err is set (partial frame discarded).
  - in_done: go to SWAP. If in_valid is high in the same cycle, that word is written first.
- SWAP (1 cycle): toggle read bank, pulse frame_ready, increment frame_count, go to IDLE. An in_valid arriving during SWAP is handled exactly as in IDLE.
- Read port:
  - Registered, latency 1, reads the read bank.
  - An rd_en in the same cycle as the bank toggle returns pre-swap data.
  - Occupancy 0 returns type 0, depth 0.
  - rd_row > 15 or rd_lane == 3 returns zeros with rd_valid = 1.
- The write bank is never the read bank. Reads never observe a partial frame.
- No backpressure: the input is a pure strobe, and every cycle's word is either stored or dropped.

Decomposition:
- Shared package obstacle_pkg holds:
  - obstacle type enum: NONE=0, LOW=1, HIGH=2, MID=3, TRAIN=4, RAMP=5, CAR=6
  - field offsets and widths: TYPE_MSB=15, LANE_LSB=11, DEPTH_WIDTH=11
  - NUM_ROWS and NUM_LANES
- One sub-module, obstacle_bank: a single 48-entry table with occupancy vector, clear, one write port and a registered read port. It is instantiated twice; the top holds the FSM and bank select.

Test Plan:
- Full frame: 48 words, row r lane l = {TRAIN, l, 64*r}, first_row set on row 0, then in_done -> one frame_ready pulse 2 cycles after in_done; frame_count = 1; read (5,2) returns type 4, depth 320.
- Sparse frame: only (0,1) = {LOW, 1, 7}, then done -> read (0,1) returns 1/7; read (3,0) returns 0/0; a value left in the bank from a prior frame must not reappear.
- Word with in_valid and in_done in the same cycle at (15,2) -> the word is stored, and read (15,2) after the swap returns it.
- Protocol errors:
  - in_valid without first_row in IDLE -> proto_err = 1, nothing stored.
  - lane = 3 -> dropped.
  - 49th word -> dropped; proto_err stays 1.
- Read during swap: rd_en in the SWAP cycle returns the old frame's data, and the next read returns the new frame's data.
- rst_n asserted mid-COLLECT (asynchronously, between clock edges) -> all outputs 0 immediately; after release, the next frame is collected correctly and frame_count restarts at 1.
